// File: rtl/group_add_sched.sv
// Sequencing controller for the group_add adder pipeline: issues group vectors,
// tracks adder latency with tags, accumulates group sums and buffers words in a credited FIFO.
module group_add_sched #(
  parameter int GROUP_NB    = 4,
  parameter int NUM_WIDTH   = 16,
  parameter int ADD_LAT     = 5,
  parameter int DEPTH_WIDTH = 8,
  parameter int COUNT_WIDTH = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_valid,
  input  logic [DEPTH_WIDTH-1:0]        cfg_depth,
  input  logic [COUNT_WIDTH-1:0]        cfg_count,
  output logic                          cfg_ready,
  input  logic [NUM_WIDTH*GROUP_NB-1:0] up_data,
  input  logic                          up_valid,
  output logic                          up_ready,
  output logic [NUM_WIDTH*GROUP_NB-1:0] add_data,
  input  logic [NUM_WIDTH-1:0]          add_result,
  output logic [NUM_WIDTH-1:0]          dn_data,
  output logic                          dn_valid,
  input  logic                          dn_ready,
  output logic                          busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [DEPTH_WIDTH-1:0]   r_depth;
  logic [COUNT_WIDTH-1:0]   r_count;
  logic [DEPTH_WIDTH-1:0]   r_term;
  logic [COUNT_WIDTH-1:0]   r_word;
  logic [CW-1:0]            r_credit;
  logic [ADD_LAT:0]         r_tag_vld;
  logic [ADD_LAT:0]         r_tag_first;
  logic [ADD_LAT:0]         r_tag_last;
  logic [NUM_WIDTH-1:0]     r_acc;
  logic [NUM_WIDTH-1:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [CW-1:0]            r_fifo_cnt;

  logic                     w_start;
  logic                     w_hs;
  logic                     w_first;
  logic                     w_last;
  logic                     w_last_word;
  logic                     w_exit_vld;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_in_flight;
  logic                     w_drained;
  logic [NUM_WIDTH-1:0]     w_sum;
  logic                     w_cfg_ready;
  logic                     w_busy;
  logic                     w_up_ready;

  assign w_start     = cfg_valid && (cfg_depth != '0) && (cfg_count != '0);
  assign w_hs        = up_valid && w_up_ready;
  assign w_first     = (r_term == '0);
  assign w_last      = (r_term == r_depth - DEPTH_WIDTH'(1));
  assign w_last_word = (r_word == r_count - COUNT_WIDTH'(1));
  assign w_exit_vld  = r_tag_vld[ADD_LAT];
  assign w_push      = w_exit_vld && r_tag_last[ADD_LAT];
  assign w_pop       = (r_fifo_cnt != '0) && dn_ready;
  assign w_in_flight = |r_tag_vld;
  // Looks one pop ahead so the controller idles right after the FIFO empties.
  assign w_drained   = !w_in_flight &&
                       ((r_fifo_cnt == '0) || ((r_fifo_cnt == CW'(1)) && w_pop));
  assign w_sum       = r_tag_first[ADD_LAT] ? add_result : (r_acc + add_result);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_RUN;
               else         w_state_next = S_IDLE;
      S_RUN:   if (w_hs && w_last && w_last_word) w_state_next = S_DRAIN;
               else                               w_state_next = S_RUN;
      S_DRAIN: if (w_drained) w_state_next = S_IDLE;
               else           w_state_next = S_DRAIN;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cfg_ready = (r_state == S_IDLE);
    w_busy      = (r_state != S_IDLE);
    w_up_ready  = (r_state == S_RUN) && ((r_term != '0) || (r_credit != '0));
  end

  assign cfg_ready = w_cfg_ready;
  assign busy      = w_busy;
  assign up_ready  = w_up_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_depth  <= '0;
      r_count  <= '0;
      r_term   <= '0;
      r_word   <= '0;
      add_data <= '0;
    end else if ((r_state == S_IDLE) && w_start) begin
      r_depth <= cfg_depth;
      r_count <= cfg_count;
      r_term  <= '0;
      r_word  <= '0;
    end else if (w_hs) begin
      add_data <= up_data;
      if (w_last) begin
        r_term <= '0;
        r_word <= r_word + COUNT_WIDTH'(1);
      end else begin
        r_term <= r_term + DEPTH_WIDTH'(1);
      end
    end
  end

  // One credit per word: taken when its first term is accepted, returned on pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credit <= CW'(FIFO_DEPTH);
    end else begin
      case ({w_hs && w_first, w_pop})
        2'b10:   r_credit <= r_credit - CW'(1);
        2'b01:   r_credit <= r_credit + CW'(1);
        default: r_credit <= r_credit;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_vld   <= '0;
      r_tag_first <= '0;
      r_tag_last  <= '0;
      r_acc       <= '0;
    end else begin
      r_tag_vld   <= {r_tag_vld[ADD_LAT-1:0], w_hs};
      r_tag_first <= {r_tag_first[ADD_LAT-1:0], w_first};
      r_tag_last  <= {r_tag_last[ADD_LAT-1:0], w_last};
      if (w_exit_vld) r_acc <= w_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_sum;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  assign dn_data  = r_mem[r_rd_ptr];
  assign dn_valid = (r_fifo_cnt != '0);

endmodule

// File: tb/tb_group_add_sched.sv
// Directed bench for group_add_sched with a behavioural 5-cycle group adder model.
module tb_group_add_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic [7:0]  cfg_depth;
  logic [7:0]  cfg_count;
  logic        cfg_ready;
  logic [63:0] up_data;
  logic        up_valid;
  logic        up_ready;
  logic [63:0] add_data;
  logic [15:0] add_result;
  logic [15:0] dn_data;
  logic        dn_valid;
  logic        dn_ready;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int stalls = 0;
  logic [15:0] got [$];

  group_add_sched dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_depth(cfg_depth), .cfg_count(cfg_count), .cfg_ready(cfg_ready),
    .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
    .add_data(add_data), .add_result(add_result),
    .dn_data(dn_data), .dn_valid(dn_valid), .dn_ready(dn_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sum4(input logic [63:0] v);
    return v[15:0] + v[31:16] + v[47:32] + v[63:48];
  endfunction

  function automatic logic [63:0] pack(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Adder model: no reset, result ADD_LAT=5 cycles after add_data.
  logic [15:0] pipe [5];
  always @(posedge clk) begin
    pipe[0] <= sum4(add_data);
    for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
  end
  assign add_result = pipe[4];

  // Collect every popped word.
  always @(negedge clk) begin
    if (!rst && dn_valid && dn_ready) got.push_back(dn_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cfg(input int d, input int c);
    cfg_valid = 1'b1;
    cfg_depth = 8'(d);
    cfg_count = 8'(c);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [63:0] d);
    int n;
    n = 0;
    up_data  = d;
    up_valid = 1'b1;
    while (!up_ready && n < 200) begin
      tick();
      n++;
      stalls++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: up_ready stuck at 0 expected 1");
    end
    tick();
    up_valid = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 300) begin
      tick();
      k++;
    end
    check("word_count", 64'(got.size()), 64'(n));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
    check("idle_reached", 64'(busy), 64'd0);
  endtask

  typedef struct {
    int          depth;
    int          count;
    logic [63:0] terms [8];
    logic [15:0] exp [4];
  } vec_t;

  vec_t tbl [4];

  initial begin
    int k;
    int seen;

    tbl[0].depth = 3; tbl[0].count = 2;
    tbl[0].terms[0] = pack(16'd1, 16'd2, 16'd3, 16'd4);
    tbl[0].terms[1] = pack(16'd5, 16'd5, 16'd5, 16'd5);
    tbl[0].terms[2] = pack(16'd10, 16'd10, 16'd5, 16'd5);
    tbl[0].terms[3] = pack(16'hFFFB, 16'd0, 16'd0, 16'd0);
    tbl[0].terms[4] = pack(16'd1, 16'd1, 16'd1, 16'd2);
    tbl[0].terms[5] = pack(16'd7, 16'd0, 16'd0, 16'd0);
    tbl[0].exp[0] = 16'd60; tbl[0].exp[1] = 16'd7;

    tbl[1].depth = 2; tbl[1].count = 1;
    tbl[1].terms[0] = pack(16'h7FFF, 16'd0, 16'd0, 16'd0);
    tbl[1].terms[1] = pack(16'h0001, 16'd0, 16'd0, 16'd0);
    tbl[1].exp[0] = 16'h8000;

    tbl[2].depth = 1; tbl[2].count = 3;
    tbl[2].terms[0] = pack(16'd1, 16'd1, 16'd1, 16'd1);
    tbl[2].terms[1] = pack(16'hFFFF, 16'd0, 16'd0, 16'd0);
    tbl[2].terms[2] = pack(16'h8000, 16'h8000, 16'd1, 16'd2);
    tbl[2].exp[0] = 16'd4; tbl[2].exp[1] = 16'hFFFF; tbl[2].exp[2] = 16'd3;

    tbl[3].depth = 2; tbl[3].count = 2;
    tbl[3].terms[0] = pack(16'd10, 16'd0, 16'd0, 16'd0);
    tbl[3].terms[1] = pack(16'd0, 16'd0, 16'd0, 16'd5);
    tbl[3].terms[2] = pack(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    tbl[3].terms[3] = pack(16'd4, 16'd0, 16'd0, 16'd0);
    tbl[3].exp[0] = 16'd15; tbl[3].exp[1] = 16'd0;

    rst = 1'b1; cfg_valid = 1'b0; cfg_depth = '0; cfg_count = '0;
    up_data = '0; up_valid = 1'b0; dn_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    check("rst_up_ready", 64'(up_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dn_valid", 64'(dn_valid), 64'd0);
    check("rst_add_data", add_data, 64'd0);

    // Single word, exact latency.
    cfg(1, 1);
    check("run_busy", 64'(busy), 64'd1);
    send(pack(16'd1, 16'd2, 16'd3, 16'd4));
    check("add_data_t1", add_data, pack(16'd1, 16'd2, 16'd3, 16'd4));
    repeat (5) tick();
    check("dn_valid_t6", 64'(dn_valid), 64'd0);
    tick();
    check("dn_valid_t7", 64'(dn_valid), 64'd1);
    check("dn_data_t7", 64'(dn_data), 64'd10);
    check("busy_before_pop", 64'(busy), 64'd1);
    dn_ready = 1'b1;
    tick();
    check("cfg_ready_after_pop", 64'(cfg_ready), 64'd1);
    check("busy_after_pop", 64'(busy), 64'd0);
    check("single_word", 64'(got.size() == 1 ? got[0] : 16'hDEAD), 64'd10);
    got.delete();

    // Table-driven jobs with downstream always ready.
    for (int v = 0; v < 4; v++) begin
      stalls = 0;
      cfg(tbl[v].depth, tbl[v].count);
      for (int t = 0; t < tbl[v].depth * tbl[v].count; t++) send(tbl[v].terms[t]);
      check($sformatf("tbl%0d_stalls", v), 64'(stalls), 64'd0);
      wait_words(tbl[v].count);
      wait_idle();
      for (int w = 0; w < tbl[v].count; w++)
        check($sformatf("tbl%0d_word%0d", v, w),
              64'(w < got.size() ? got[w] : 16'hDEAD), 64'(tbl[v].exp[w]));
      got.delete();
    end

    // Backpressure: only FIFO_DEPTH words may be started.
    dn_ready = 1'b0;
    cfg(1, 8);
    k = 0;
    for (int c = 0; c < 30; c++) begin
      up_valid = 1'b1;
      up_data  = pack(16'(k + 1), 16'd0, 16'd0, 16'd0);
      if (up_ready) begin
        tick();
        k++;
      end else begin
        tick();
      end
    end
    up_valid = 1'b0;
    check("bp_accepted", 64'(k), 64'd4);
    check("bp_up_ready", 64'(up_ready), 64'd0);
    check("bp_dn_valid", 64'(dn_valid), 64'd1);
    dn_ready = 1'b1;
    for (int j = k; j < 8; j++) send(pack(16'(j + 1), 16'd0, 16'd0, 16'd0));
    wait_words(8);
    wait_idle();
    for (int w = 0; w < 8; w++)
      check($sformatf("bp_word%0d", w), 64'(w < got.size() ? got[w] : 16'hDEAD), 64'(w + 1));
    got.delete();

    // Reset with three terms in flight.
    cfg(1, 8);
    send(pack(16'd9, 16'd0, 16'd0, 16'd0));
    send(pack(16'd8, 16'd0, 16'd0, 16'd0));
    send(pack(16'd7, 16'd0, 16'd0, 16'd0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (dn_valid) seen++;
      tick();
    end
    check("rst_mid_no_dn_valid", 64'(seen), 64'd0);
    check("rst_mid_cfg_ready", 64'(cfg_ready), 64'd1);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_no_words", 64'(got.size()), 64'd0);
    got.delete();
    cfg(1, 1);
    send(pack(16'd2, 16'd3, 16'd4, 16'd5));
    wait_words(1);
    wait_idle();
    check("rst_mid_new_job", 64'(got.size() > 0 ? got[0] : 16'hDEAD), 64'd14);
    got.delete();

    // Illegal configuration in IDLE.
    cfg(0, 3);
    check("cfg_depth0_busy", 64'(busy), 64'd0);
    check("cfg_depth0_ready", 64'(cfg_ready), 64'd1);
    cfg(2, 0);
    check("cfg_count0_busy", 64'(busy), 64'd0);

    // Late configuration during RUN is ignored.
    cfg(2, 1);
    send(pack(16'd1, 16'd1, 16'd1, 16'd1));
    cfg_valid = 1'b1;
    cfg_depth = 8'd1;
    cfg_count = 8'd5;
    send(pack(16'd2, 16'd2, 16'd2, 16'd2));
    cfg_valid = 1'b0;
    wait_words(1);
    wait_idle();
    repeat (10) tick();
    check("late_cfg_words", 64'(got.size()), 64'd1);
    check("late_cfg_sum", 64'(got.size() > 0 ? got[0] : 16'hDEAD), 64'd12);
    check("late_cfg_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
